// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that forwards one byte at a time from N_REQ requesters to a
// single UART transmitter, with an issue timeout and a guaranteed low gap between frames.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ISSUE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_data_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gap_q, gap_d;

  logic [N_REQ-1:0] req_ready_d;
  logic             tx_valid_d;
  logic [7:0]       tx_data_d;
  logic [2:0]       grant_id_d;
  logic             busy_d;
  logic             err_d;

  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  winner;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;
  logic [7:0]       win_byte;

  // (base + off) mod N_REQ; both operands are already below N_REQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return ID_W'(sum);
  endfunction

  // First valid requester at or after rr_ptr in circular order
  always_comb begin
    cand      = '0;
    winner    = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!win_found && (|(req_valid & (N_REQ'(1) << cand)))) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
    win_onehot = N_REQ'(1) << winner;
    win_byte   = 8'(req_data >> {winner, 3'b000});
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    req_ready_d = '0;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data;
    grant_id_d  = grant_id;
    err_d       = err_timeout;

    case (state_q)
      IDLE: begin
        if (win_found && tx_ready) begin
          state_d     = ISSUE;
          rr_ptr_d    = wrap_idx(winner, 1);
          cnt_d       = '0;
          req_ready_d = win_onehot;
          tx_valid_d  = 1'b1;
          tx_data_d   = win_byte;
          grant_id_d  = 3'(winner);
        end
      end
      ISSUE: begin
        if (!tx_ready) begin
          state_d = DRAIN;
        end else if (cnt_q >= CNT_LAST) begin
          // Transmitter never took the byte: drop it and flag the error
          err_d   = 1'b1;
          state_d = GAP;
          gap_d   = 1'b0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          tx_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (tx_ready) begin
          state_d = GAP;
          gap_d   = 1'b0;
        end
      end
      GAP: begin
        if (gap_q) state_d = IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      gap_q         <= 1'b0;
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      req_ready     <= req_ready_d;
      tx_data_valid <= tx_valid_d;
      tx_data       <= tx_data_d;
      grant_id      <= grant_id_d;
      busy          <= busy_d;
      err_timeout   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, timeout/reset sequences and a random
// phase checked by a transaction-level round-robin model and a transmitter model.
module tb_uart_tx_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int          FRAME   = 6;
  localparam logic [31:0] DATA    = 32'hA3A2A1A0;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_data_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [2:0]     grant_id;
  logic           busy;
  logic           err_timeout;

  uart_tx_arbiter #(.N_REQ(N), .ISSUE_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int         passed = 0;
  int         total  = 0;
  int         mptr   = 0;
  int         grants = 0;
  bit         stuck  = 1'b0;
  bit         xbusy  = 1'b0;
  int         xcnt   = 0;
  logic       xprev  = 1'b0;
  logic       mprev  = 1'b0;
  int         low_run = 100;
  logic [7:0] sb[$];

  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    bit             drop;
    int             exp_grant;
    logic [7:0]     exp_byte;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: event absent or illegal, required otherwise (t=%0t)", name, $time);
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int p);
    int idx;
    for (int k = 0; k < int'(N); k++) begin
      idx = (p + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Grant model, one-hot/ready rules and the low-gap rule on tx_data_valid
  task automatic monitor();
    int ew;
    if (tx_data_valid && !mprev) check("gap_before_rise", 32'(low_run >= 2), 32'd1);
    low_run = tx_data_valid ? 0 : low_run + 1;
    mprev   = tx_data_valid;
    if (req_ready != '0) begin
      grants++;
      check("ready_onehot", 32'($countones(req_ready)), 32'd1);
      check("grant_needs_tx_ready", 32'(tx_ready), 32'd1);
      ew = first_from(req_valid, mptr);
      if (ew < 0) fail("grant_without_valid");
      else begin
        check("model_grant_id", 32'(grant_id), 32'(ew));
        check("model_tx_data", 32'(tx_data), 32'(8'(req_data >> (8 * ew))));
        mptr = (ew + 1) % int'(N);
        if (!stuck) sb.push_back(8'(req_data >> (8 * ew)));
      end
    end
  endtask

  // Transmitter: starts a frame on a valid rising edge, tx_ready lags one cycle
  task automatic xmit();
    logic rise;
    rise  = tx_data_valid && !xprev;
    xprev = tx_data_valid;
    tx_ready = stuck ? 1'b1 : !xbusy;
    if (!stuck) begin
      if (xbusy) begin
        if (rise) fail("rise_while_tx_busy");
        if (xcnt == 0) xbusy = 1'b0;
        else xcnt--;
      end else if (rise) begin
        xbusy = 1'b1;
        xcnt  = FRAME;
        if (sb.size() == 0) fail("frame_unexpected");
        else check("frame_byte", 32'(tx_data), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    xmit();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_data_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 80 && busy; c++) tick();
    if (busy) fail("wait_idle");
  endtask

  task automatic do_txn(input logic [N-1:0] v, input logic [8*N-1:0] d, input int exp_g,
                        input logic [7:0] exp_b, input int exp_hi, input bit exp_err,
                        input bit drop);
    bit got;
    int hi;
    req_valid = v;
    req_data  = d;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      got = (req_ready != '0);
    end
    if (!got) begin
      fail("grant_wait");
      return;
    end
    check("txn_grant_id", 32'(grant_id), 32'(exp_g));
    check("txn_req_ready", 32'(req_ready), 32'(1 << exp_g));
    check("txn_tx_data", 32'(tx_data), 32'(exp_b));
    check("txn_tx_valid", 32'(tx_data_valid), 32'd1);
    if (drop) req_valid = '0;
    hi = 1;
    tick();
    check("ready_pulse_len", 32'(req_ready), 32'd0);
    if (tx_data_valid) hi++;
    while (tx_data_valid && hi < 80) begin
      tick();
      if (tx_data_valid) hi++;
    end
    check("valid_high_cycles", 32'(hi), 32'(exp_hi));
    check("busy_after_issue", 32'(busy), 32'd1);
    check("err_after_issue", 32'(err_timeout), 32'(exp_err));
    wait_idle();
    check("err_after_gap", 32'(err_timeout), 32'(exp_err));
  endtask

  initial begin
    bit got;
    int g0;

    tbl[0]  = '{4'b0001, 32'hA3A2A155, 1'b1, 0, 8'h55};
    tbl[1]  = '{4'b1111, DATA, 1'b0, 1, 8'hA1};
    tbl[2]  = '{4'b1111, DATA, 1'b0, 2, 8'hA2};
    tbl[3]  = '{4'b1111, DATA, 1'b0, 3, 8'hA3};
    tbl[4]  = '{4'b0011, DATA, 1'b1, 0, 8'hA0};
    tbl[5]  = '{4'b1111, DATA, 1'b0, 1, 8'hA1};
    tbl[6]  = '{4'b1101, DATA, 1'b1, 2, 8'hA2};
    tbl[7]  = '{4'b0001, DATA, 1'b1, 0, 8'hA0};
    tbl[8]  = '{4'b1000, DATA, 1'b1, 3, 8'hA3};
    tbl[9]  = '{4'b0110, DATA, 1'b1, 1, 8'hA1};
    tbl[10] = '{4'b0110, DATA, 1'b1, 2, 8'hA2};
    tbl[11] = '{4'b0110, DATA, 1'b1, 1, 8'hA1};

    rst       = 1'b1;
    req_valid = '1;
    req_data  = DATA;
    tx_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset");
    end
    rst       = 1'b0;
    req_valid = '0;
    mptr      = 0;
    tick();

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].valid, tbl[i].data, tbl[i].exp_grant, tbl[i].exp_byte, 2, 1'b0, tbl[i].drop);

    // Transmitter never accepts: byte dropped after the timeout, error sticks
    stuck = 1'b1;
    do_txn(4'b0100, DATA, 2, 8'hA2, int'(TIMEOUT), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("err_sticky", 32'(err_timeout), 32'd1);
    do_txn(4'b0001, DATA, 0, 8'hA0, int'(TIMEOUT), 1'b1, 1'b1);
    stuck = 1'b0;
    tick();

    // Reset while draining a frame
    req_valid = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      got = (req_ready != '0);
    end
    if (!got) fail("drain_grant_wait");
    check("drain_grant_id", 32'(grant_id), 32'd1);
    for (int c = 0; c < 40 && tx_data_valid; c++) tick();
    check("drain_valid_low", 32'(tx_data_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    rst  = 1'b1;
    mptr = 0;
    tick();
    check_reset_outputs("rst_drain");
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      tick();
      got = (req_ready != '0);
    end
    if (!got) fail("post_reset_grant_wait");
    check("post_reset_grant_id", 32'(grant_id), 32'd1);
    req_valid = '0;
    wait_idle();

    // Random traffic against the round-robin model and transmitter scoreboard
    g0 = grants;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
      if ($urandom_range(0, 7) == 0) req_data = $urandom;
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 80; c++) tick();
    check("random_grants_min", 32'((grants - g0) >= 50), 32'd1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);
    check("final_err_clear", 32'(err_timeout), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter ISSUE_TIMEOUT, default 16, the number of clk cycles to wait for the transmitter to accept a byte.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte pending.
REQ-006 SHALL have port req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
REQ-008 SHALL have port tx_data_valid  output  1  level to transmitter; the transmitter starts a frame on its rising edge.
REQ-009 SHALL have port tx_data  output  8  byte to transmitter.
REQ-010 SHALL have port tx_ready  input  1  transmitter idle (registered, lags its state by 1 cycle).
REQ-011 SHALL have port grant_id  output  3  index of the requester whose byte is in flight.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port err_timeout  output  1  sticky; set when the transmitter fails to accept within ISSUE_TIMEOUT.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, DRAIN and GAP; all outputs are registered.
REQ-015 In IDLE, with any req_valid high and tx_ready=1, SHALL grant the first requester at or after rr_ptr in circular order: latch its byte into tx_data, set grant_id, pulse its req_ready bit for exactly 1 cycle, and go to ISSUE.
REQ-016 SHALL set rr_ptr to (winner+1) mod N_REQ on each grant; at most one req_ready bit is high in any cycle.
REQ-017 In IDLE with tx_ready=0, SHALL make no grant and keep req_ready all-zero.
REQ-018 In ISSUE, SHALL drive tx_data_valid=1 with tx_data held stable; when tx_ready=0 is sampled, SHALL go to DRAIN and drive tx_data_valid=0 from the next cycle.
REQ-019 In ISSUE, SHALL count cycles; if the count reaches ISSUE_TIMEOUT with tx_ready still 1, SHALL set err_timeout and go to GAP, and the byte is dropped without retry.
REQ-020 In DRAIN, SHALL hold tx_data_valid=0 and tx_data stable, and go to GAP when tx_ready=1 is sampled.
REQ-021 In GAP, SHALL hold tx_data_valid=0 for exactly 2 cycles, then go to IDLE, so the transmitter's 2-flop synchronizer sees a clean low before the next rising edge.
REQ-022 SHALL drop tx_data_valid to 0 whenever the FSM leaves ISSUE by either exit.
REQ-023 SHALL ignore a requester dropping req_valid after its grant; the latched byte is still sent.
REQ-024 SHALL ignore a requester dropping req_valid before its grant; it is not granted.
REQ-025 SHALL keep err_timeout set until rst and SHALL not block further arbitration with it.
REQ-026 SHALL keep the ISSUE timeout counter at least clog2(ISSUE_TIMEOUT+1) bits wide and clear it on ISSUE entry.

Reset
REQ-027 While rst=1, SHALL hold state=IDLE, rr_ptr=0, req_ready=0, tx_data_valid=0, tx_data=0, grant_id=0, busy=0, err_timeout=0 and the timeout counter at 0.
REQ-028 On reset asserted mid-transfer (any state), SHALL return to IDLE on the next edge, and any latched byte is discarded.
REQ-029 After rst deasserts, SHALL make the first grant no earlier than the first cycle with tx_ready=1.

Verification
REQ-030 Single requester: req_valid=4'b0001, byte 0x55, with the transmitter model -> req_ready[0] high for 1 cycle; tx_data=0x55; tx_data_valid high until tx_ready falls; busy until GAP ends; err_timeout stays 0.
REQ-031 Round-robin: all four requesters valid continuously, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; each requester gets exactly one req_ready pulse per 4 grants.
REQ-032 Pointer wrap: grant to requester 3, then only req_valid[1] and req_valid[0] high -> next grant goes to 0, not 1.
REQ-033 Timeout: tx_ready tied to 1 and never falling -> tx_data_valid drops after 16 ISSUE cycles; err_timeout=1 and stays 1; a following request is still granted.
REQ-034 Reset in DRAIN: rst pulsed for 1 cycle -> next cycle state=IDLE with all outputs at reset values; no spurious req_ready.
REQ-035 Back-to-back: every frame's tx_data_valid rising edge is preceded by at least 2 low cycles, checked on the tx_data_valid waveform.
